m_connect_game_ctrl: RTL and testbench

//  Parametrised two-player drop-piece (connect-N) game controller; successor to the fixed 7x6 controller.

---
 rtl/m_connect_game_ctrl_if.sv | 29 ++
 rtl/m_connect_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_m_connect_game_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_connect_game_ctrl_if.sv
// Board-controller bus: button pulses in, cursor/board/status registers out.
// The controller attaches through the slave modport; the button side (or a bench) uses master.
interface m_connect_game_ctrl_if #(
    parameter int COLS = 7,
    parameter int ROWS = 6
);
    logic [3:0]                        i_user_input;
    logic                              i_first_blue;
    logic [$clog2(COLS)-1:0]           o_selecting_col;
    logic [COLS*ROWS-1:0]              o_red_field;
    logic [COLS*ROWS-1:0]              o_blue_field;
    logic                              o_turn;
    logic [$clog2(COLS*ROWS+1)-1:0]    o_move_count;
    logic [1:0]                        o_settlement_state;
    logic                              o_reject;
    logic                              o_timeout;

    modport master (
        output i_user_input, i_first_blue,
        input  o_selecting_col, o_red_field, o_blue_field, o_turn,
               o_move_count, o_settlement_state, o_reject, o_timeout
    );

    modport slave (
        input  i_user_input, i_first_blue,
        output o_selecting_col, o_red_field, o_blue_field, o_turn,
               o_move_count, o_settlement_state, o_reject, o_timeout
    );
endinterface

// File: rtl/m_connect_game_ctrl.sv
// Two-player connect-N controller: cursor, piece drop with gravity, win/draw detection,
// optional per-turn timeout. Every output is a register.
module m_connect_game_ctrl #(
    parameter int COLS         = 7,
    parameter int ROWS         = 6,
    parameter int WIN_LEN      = 4,
    parameter int HOLD_CYCLES  = 3,
    parameter int TURN_TIMEOUT = 0
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    m_connect_game_ctrl_if.slave bus
);
    localparam int NCELL = COLS * ROWS;
    localparam int CW    = $clog2(COLS);
    localparam int HW    = $clog2(ROWS + 1);
    localparam int MW    = $clog2(NCELL + 1);
    localparam int TW    = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam int HCW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CW-1:0]  COL_MAX = CW'(COLS - 1);
    localparam logic [HW-1:0]  H_FULL  = HW'(ROWS);
    localparam logic [MW-1:0]  MC_FULL = MW'(NCELL);
    localparam logic [TW-1:0]  T_LAST  = TW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);
    localparam logic [HCW-1:0] H_LAST  = HCW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    localparam logic [3:0] IN_INC  = 4'b1000;
    localparam logic [3:0] IN_DEC  = 4'b0100;
    localparam logic [3:0] IN_DROP = 4'b0001;

    typedef enum logic [2:0] {SELECT, PLACE, CHECK, HOLD, OVER} state_t;

    state_t           state;
    logic [CW-1:0]    col;
    logic [NCELL-1:0] red;
    logic [NCELL-1:0] blue;
    logic             turn;
    logic [MW-1:0]    move_count;
    logic [1:0]       settle;
    logic             reject;
    logic             timeout;
    logic [HW-1:0]    heights [COLS];
    logic [TW-1:0]    timer;
    logic [HCW-1:0]   hold_cnt;

    logic [HW-1:0]    cur_h;
    logic [NCELL-1:0] place_mask;
    logic             win;

    // Out-of-board coordinates read as empty, so lines never wrap between rows.
    function automatic logic cell_at(input logic [NCELL-1:0] f, input int r, input int c);
        logic [NCELL-1:0] sh;
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
        sh = f >> (r * COLS + c);
        return sh[0];
    endfunction

    function automatic logic has_line(input logic [NCELL-1:0] f);
        logic hit, h, v, d, a;
        hit = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                h = 1'b1;
                v = 1'b1;
                d = 1'b1;
                a = 1'b1;
                for (int k = 0; k < WIN_LEN; k++) begin
                    h = h & cell_at(f, r, c + k);
                    v = v & cell_at(f, r + k, c);
                    d = d & cell_at(f, r + k, c + k);
                    a = a & cell_at(f, r + k, c - k);
                end
                hit = hit | h | v | d | a;
            end
        end
        return hit;
    endfunction

    always_comb begin
        cur_h = '0;
        for (int c = 0; c < COLS; c++)
            if (col == CW'(c)) cur_h = heights[c];
    end

    always_comb begin
        place_mask = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (col == CW'(c) && cur_h == HW'(r)) place_mask[r*COLS + c] = 1'b1;
    end

    assign win = has_line(turn ? blue : red);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state      <= SELECT;
            col        <= '0;
            red        <= '0;
            blue       <= '0;
            turn       <= bus.i_first_blue;
            move_count <= '0;
            settle     <= 2'b00;
            reject     <= 1'b0;
            timeout    <= 1'b0;
            timer      <= '0;
            hold_cnt   <= '0;
            for (int c = 0; c < COLS; c++) heights[c] <= '0;
        end else begin
            reject  <= 1'b0;
            timeout <= 1'b0;
            case (state)
                SELECT: begin
                    if (bus.i_user_input == IN_DROP) begin
                        state <= PLACE;
                    end else begin
                        if (bus.i_user_input == IN_INC)
                            col <= (col == COL_MAX) ? '0 : col + CW'(1);
                        else if (bus.i_user_input == IN_DEC)
                            col <= (col == '0) ? COL_MAX : col - CW'(1);
                        if (TURN_TIMEOUT > 0) begin
                            if (timer == T_LAST) begin
                                turn    <= ~turn;
                                timeout <= 1'b1;
                                timer   <= '0;
                            end else begin
                                timer <= timer + TW'(1);
                            end
                        end
                    end
                end
                PLACE: begin
                    // A full column keeps the timer running so a reject cannot stall the clock.
                    if (cur_h == H_FULL) begin
                        reject <= 1'b1;
                        state  <= SELECT;
                    end else begin
                        if (turn) blue <= blue | place_mask;
                        else      red  <= red | place_mask;
                        for (int c = 0; c < COLS; c++)
                            if (col == CW'(c)) heights[c] <= heights[c] + HW'(1);
                        move_count <= move_count + MW'(1);
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (win) begin
                        settle <= {1'b1, turn};
                        state  <= OVER;
                    end else if (move_count == MC_FULL) begin
                        settle <= 2'b01;
                        state  <= OVER;
                    end else begin
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == H_LAST) begin
                        turn  <= ~turn;
                        timer <= '0;
                        state <= SELECT;
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                OVER:    ;
                default: state <= SELECT;
            endcase
        end
    end

    assign bus.o_selecting_col    = col;
    assign bus.o_red_field        = red;
    assign bus.o_blue_field       = blue;
    assign bus.o_turn             = turn;
    assign bus.o_move_count       = move_count;
    assign bus.o_settlement_state = settle;
    assign bus.o_reject           = reject;
    assign bus.o_timeout          = timeout;
endmodule

// File: tb/tb_m_connect_game_ctrl.sv
// Bench for the connect-N controller: a 7x6 game table plus a 2x2 instance with turn timeout.
module tb_m_connect_game_ctrl;
    localparam int K_RESET = 0, K_INC = 1, K_DEC = 2, K_RAW = 3, K_DROP = 4;
    localparam logic [3:0] C_INC = 4'b1000, C_DEC = 4'b0100, C_DROP = 4'b0001;

    typedef struct {
        int          kind;
        int          arg;
        int          col;
        int          turn;
        int          mc;
        int          st;
        bit          chk;
        logic [63:0] red;
        logic [63:0] blue;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    m_connect_game_ctrl_if #(.COLS(7), .ROWS(6)) bus_a ();
    m_connect_game_ctrl_if #(.COLS(2), .ROWS(2)) bus_b ();

    m_connect_game_ctrl #(.COLS(7), .ROWS(6), .WIN_LEN(4), .HOLD_CYCLES(3), .TURN_TIMEOUT(0))
        dut_a (.w_clk(clk), .w_rst(rst_a), .bus(bus_a));
    m_connect_game_ctrl #(.COLS(2), .ROWS(2), .WIN_LEN(3), .HOLD_CYCLES(3), .TURN_TIMEOUT(10))
        dut_b (.w_clk(clk), .w_rst(rst_b), .bus(bus_b));

    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;
    vec_t tab [43];
    vec_t sb [$];

    function automatic vec_t mk(input int kind, input int arg, input int col, input int turn,
                                input int mc, input int st, input bit chk,
                                input logic [63:0] red, input logic [63:0] blue);
        vec_t v;
        v.kind = kind; v.arg = arg; v.col = col; v.turn = turn;
        v.mc = mc; v.st = st; v.chk = chk; v.red = red; v.blue = blue;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int which, input logic [3:0] code);
        @(negedge clk);
        if (which == 0) bus_a.i_user_input = code;
        else            bus_b.i_user_input = code;
        @(negedge clk);
        if (which == 0) bus_a.i_user_input = 4'b0;
        else            bus_b.i_user_input = 4'b0;
    endtask

    task automatic reset_dut(input int which, input logic fb);
        @(negedge clk);
        if (which == 0) begin rst_a = 1'b1; bus_a.i_first_blue = fb; bus_a.i_user_input = 4'b0; end
        else            begin rst_b = 1'b1; bus_b.i_first_blue = fb; bus_b.i_user_input = 4'b0; end
        idle(2);
        if (which == 0) begin rst_a = 1'b0; cur = 0; end
        else            rst_b = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        sb.push_back(v);
        case (v.kind)
            K_RESET: reset_dut(0, v.arg[0]);
            K_INC:   begin pulse(0, C_INC); cur = (cur + 1) % 7; end
            K_DEC:   begin pulse(0, C_DEC); cur = (cur + 6) % 7; end
            K_RAW:   pulse(0, 4'(v.arg));
            default: begin
                while (cur != v.arg) begin
                    pulse(0, C_INC);
                    cur = (cur + 1) % 7;
                end
                pulse(0, C_DROP);
            end
        endcase
        idle(8);
    endtask

    task automatic compare_next(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", idx), 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check($sformatf("v%0d col", idx),    64'(bus_a.o_selecting_col),    64'(e.col));
        check($sformatf("v%0d turn", idx),   64'(bus_a.o_turn),             64'(e.turn));
        check($sformatf("v%0d count", idx),  64'(bus_a.o_move_count),       64'(e.mc));
        check($sformatf("v%0d settle", idx), 64'(bus_a.o_settlement_state), 64'(e.st));
        check($sformatf("v%0d reject", idx), 64'(bus_a.o_reject),           64'd0);
        if (e.chk) begin
            check($sformatf("v%0d red", idx),  64'(bus_a.o_red_field),  e.red);
            check($sformatf("v%0d blue", idx), 64'(bus_a.o_blue_field), e.blue);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            apply_vec(tab[i]);
            compare_next(i);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_a.i_user_input = 4'b0; bus_a.i_first_blue = 1'b0;
        bus_b.i_user_input = 4'b0; bus_b.i_first_blue = 1'b0;

        tab[0]  = mk(K_RESET, 0,    0, 0, 0, 0, 1, 64'h0, 64'h0);
        tab[1]  = mk(K_DEC,   0,    6, 0, 0, 0, 0, 64'h0, 64'h0);
        tab[2]  = mk(K_INC,   0,    0, 0, 0, 0, 0, 64'h0, 64'h0);
        tab[3]  = mk(K_RAW,   'hC,  0, 0, 0, 0, 0, 64'h0, 64'h0);
        tab[4]  = mk(K_RAW,   'h3,  0, 0, 0, 0, 1, 64'h0, 64'h0);
        tab[5]  = mk(K_DROP,  0,    0, 1, 1, 0, 1, 64'h1, 64'h0);
        tab[6]  = mk(K_DROP,  1,    1, 0, 2, 0, 1, 64'h1, 64'h2);
        tab[7]  = mk(K_DROP,  0,    0, 1, 3, 0, 0, 64'h0, 64'h0);
        tab[8]  = mk(K_DROP,  1,    1, 0, 4, 0, 0, 64'h0, 64'h0);
        tab[9]  = mk(K_DROP,  0,    0, 1, 5, 0, 0, 64'h0, 64'h0);
        tab[10] = mk(K_DROP,  1,    1, 0, 6, 0, 1, 64'h4081, 64'h8102);
        tab[11] = mk(K_RAW,   'h8,  0, 0, 7, 2, 0, 64'h0, 64'h0);
        tab[12] = mk(K_RAW,   'h1,  0, 0, 7, 2, 1, 64'h204081, 64'h8102);
        tab[13] = mk(K_RESET, 0,    0, 0, 0, 0, 1, 64'h0, 64'h0);
        tab[14] = mk(K_DROP,  3,    3, 1, 1, 0, 0, 64'h0, 64'h0);
        tab[15] = mk(K_DROP,  3,    3, 0, 2, 0, 0, 64'h0, 64'h0);
        tab[16] = mk(K_DROP,  3,    3, 1, 3, 0, 0, 64'h0, 64'h0);
        tab[17] = mk(K_DROP,  3,    3, 0, 4, 0, 0, 64'h0, 64'h0);
        tab[18] = mk(K_DROP,  3,    3, 1, 5, 0, 0, 64'h0, 64'h0);
        tab[19] = mk(K_DROP,  3,    3, 0, 6, 0, 1, 64'h80020008, 64'h4001000400);
        tab[20] = mk(K_DROP,  3,    3, 0, 6, 0, 1, 64'h80020008, 64'h4001000400);
        tab[21] = mk(K_RESET, 0,    0, 0, 0, 0, 1, 64'h0, 64'h0);
        tab[22] = mk(K_DROP,  5,    5, 1, 1, 0, 0, 64'h0, 64'h0);
        tab[23] = mk(K_DROP,  0,    0, 0, 2, 0, 0, 64'h0, 64'h0);
        tab[24] = mk(K_DROP,  6,    6, 1, 3, 0, 0, 64'h0, 64'h0);
        tab[25] = mk(K_DROP,  1,    1, 0, 4, 0, 0, 64'h0, 64'h0);
        tab[26] = mk(K_DROP,  0,    0, 1, 5, 0, 0, 64'h0, 64'h0);
        tab[27] = mk(K_DROP,  2,    2, 0, 6, 0, 0, 64'h0, 64'h0);
        tab[28] = mk(K_DROP,  1,    1, 1, 7, 0, 1, 64'h1E0, 64'h7);
        tab[29] = mk(K_RESET, 1,    0, 1, 0, 0, 1, 64'h0, 64'h0);
        tab[30] = mk(K_DROP,  0,    0, 0, 1, 0, 0, 64'h0, 64'h0);
        tab[31] = mk(K_DROP,  1,    1, 1, 2, 0, 0, 64'h0, 64'h0);
        tab[32] = mk(K_DROP,  1,    1, 0, 3, 0, 0, 64'h0, 64'h0);
        tab[33] = mk(K_DROP,  2,    2, 1, 4, 0, 0, 64'h0, 64'h0);
        tab[34] = mk(K_DROP,  6,    6, 0, 5, 0, 0, 64'h0, 64'h0);
        tab[35] = mk(K_DROP,  2,    2, 1, 6, 0, 0, 64'h0, 64'h0);
        tab[36] = mk(K_DROP,  2,    2, 0, 7, 0, 0, 64'h0, 64'h0);
        tab[37] = mk(K_DROP,  3,    3, 1, 8, 0, 0, 64'h0, 64'h0);
        tab[38] = mk(K_DROP,  6,    6, 0, 9, 0, 0, 64'h0, 64'h0);
        tab[39] = mk(K_DROP,  3,    3, 1, 10, 0, 0, 64'h0, 64'h0);
        tab[40] = mk(K_DROP,  6,    6, 0, 11, 0, 0, 64'h0, 64'h0);
        tab[41] = mk(K_DROP,  3,    3, 1, 12, 0, 0, 64'h0, 64'h0);
        tab[42] = mk(K_DROP,  3,    3, 1, 13, 3, 1, 64'h2060E, 64'h1112141);

        // Reset, cursor wrap, invalid codes, six moves of a vertical race.
        run_range(0, 10);

        // Seventh drop wins for red; settlement must appear exactly three cycles after the drop.
        pulse(0, C_DEC); cur = 0;
        pulse(0, C_DROP);
        check("win_t1 count", 64'(bus_a.o_move_count), 64'd6);
        @(negedge clk);
        check("win_t2 count", 64'(bus_a.o_move_count), 64'd7);
        check("win_t2 settle", 64'(bus_a.o_settlement_state), 64'd0);
        @(negedge clk);
        check("win_t3 settle", 64'(bus_a.o_settlement_state), 64'd2);

        // Ignored input after the win, then fill column 3.
        run_range(11, 19);

        // Drop into the full column: one-cycle reject, nothing else changes.
        pulse(0, C_DROP);
        check("rej_t1 reject", 64'(bus_a.o_reject), 64'd0);
        @(negedge clk);
        check("rej_t2 reject", 64'(bus_a.o_reject), 64'd1);
        check("rej_t2 count", 64'(bus_a.o_move_count), 64'd6);
        @(negedge clk);
        check("rej_t3 reject", 64'(bus_a.o_reject), 64'd0);
        check("rej_t3 turn", 64'(bus_a.o_turn), 64'd0);
        idle(2);

        // Second reject via the table, horizontal wrap game, blue diagonal win.
        run_range(20, 42);

        // Reset while in CHECK with first_blue=1.
        reset_dut(0, 1'b0);
        pulse(0, C_INC);
        pulse(0, C_DROP);
        @(negedge clk);
        check("rstchk pre count", 64'(bus_a.o_move_count), 64'd1);
        rst_a = 1'b1; bus_a.i_first_blue = 1'b1;
        @(negedge clk);
        check("rstchk col", 64'(bus_a.o_selecting_col), 64'd0);
        check("rstchk red", 64'(bus_a.o_red_field), 64'd0);
        check("rstchk count", 64'(bus_a.o_move_count), 64'd0);
        check("rstchk turn", 64'(bus_a.o_turn), 64'd1);
        check("rstchk settle", 64'(bus_a.o_settlement_state), 64'd0);
        check("rstchk reject", 64'(bus_a.o_reject), 64'd0);
        check("rstchk timeout", 64'(bus_a.o_timeout), 64'd0);
        rst_a = 1'b0;

        // Reset while in HOLD: blue's piece is on the board and turn has not flipped yet.
        pulse(0, C_DROP);
        idle(2);
        check("rsthold pre blue", 64'(bus_a.o_blue_field), 64'd1);
        check("rsthold pre turn", 64'(bus_a.o_turn), 64'd1);
        rst_a = 1'b1; bus_a.i_first_blue = 1'b0;
        @(negedge clk);
        check("rsthold turn", 64'(bus_a.o_turn), 64'd0);
        check("rsthold blue", 64'(bus_a.o_blue_field), 64'd0);
        check("rsthold count", 64'(bus_a.o_move_count), 64'd0);
        rst_a = 1'b0;

        // 2x2 board, win length 3: four pieces fill it and the game is a draw.
        reset_dut(1, 1'b0);
        check("b_rst col", 64'(bus_b.o_selecting_col), 64'd0);
        check("b_rst turn", 64'(bus_b.o_turn), 64'd0);
        pulse(1, C_DROP); idle(7);
        pulse(1, C_INC);  pulse(1, C_DROP); idle(7);
        pulse(1, C_DEC);  pulse(1, C_DROP); idle(7);
        pulse(1, C_INC);  pulse(1, C_DROP); idle(7);
        check("b_draw settle", 64'(bus_b.o_settlement_state), 64'd1);
        check("b_draw count", 64'(bus_b.o_move_count), 64'd4);
        check("b_draw red", 64'(bus_b.o_red_field), 64'h5);
        check("b_draw blue", 64'(bus_b.o_blue_field), 64'hA);
        check("b_draw turn", 64'(bus_b.o_turn), 64'd1);
        pulse(1, C_DEC); pulse(1, C_DROP); idle(7);
        check("b_over count", 64'(bus_b.o_move_count), 64'd4);
        check("b_over col", 64'(bus_b.o_selecting_col), 64'd1);

        // Timeout after ten idle SELECT cycles; then a drop on the expiry cycle wins.
        reset_dut(1, 1'b0);
        idle(9);
        check("b_to9 timeout", 64'(bus_b.o_timeout), 64'd0);
        check("b_to9 turn", 64'(bus_b.o_turn), 64'd0);
        idle(1);
        check("b_to10 timeout", 64'(bus_b.o_timeout), 64'd1);
        check("b_to10 turn", 64'(bus_b.o_turn), 64'd1);
        idle(1);
        check("b_to11 timeout", 64'(bus_b.o_timeout), 64'd0);
        idle(8);
        bus_b.i_user_input = C_DROP;
        @(negedge clk);
        bus_b.i_user_input = 4'b0;
        check("b_race timeout", 64'(bus_b.o_timeout), 64'd0);
        check("b_race turn", 64'(bus_b.o_turn), 64'd1);
        idle(8);
        check("b_race count", 64'(bus_b.o_move_count), 64'd1);
        check("b_race blue", 64'(bus_b.o_blue_field), 64'h1);
        check("b_race red", 64'(bus_b.o_red_field), 64'h0);
        check("b_race turn_after", 64'(bus_b.o_turn), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
